// File: rtl/diagram_step_ctrl.sv
// APB-programmable sequencer for the diagram step engine: issues start pulses against
// the ready/finish handshake for a programmed iteration count, with a per-iteration watchdog.
//
// state    | meaning
// IDLE     | waiting for an accepted GO
// WAIT_RDY | waiting for eng_ready before the next iteration
// START    | single eng_start pulse cycle
// RUN      | waiting for eng_finish
// DONE     | all iterations finished; DONE flag set on exit
module diagram_step_ctrl #(
    parameter int unsigned ITER_W      = 16,
    parameter logic [31:0] TMO_DEFAULT = 32'h000F_FFFF,
    parameter int unsigned CYC_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        eng_start,
    input  logic        eng_ready,
    input  logic        eng_finish,
    output logic        busy,
    output logic        irq
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_START    = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [7:0]       A_CTRL    = 8'h00;
    localparam logic [7:0]       A_STATUS  = 8'h04;
    localparam logic [7:0]       A_TIMEOUT = 8'h08;
    localparam logic [7:0]       A_CYCLES  = 8'h0C;
    localparam logic [CYC_W-1:0] CYC_ONES  = '1;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] run_iter_q, run_iter_d;
    logic [ITER_W-1:0] iter_done_q, iter_done_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              aborted_q, aborted_d;
    logic              spur_q, spur_d;
    logic              badgo_q, badgo_d;
    logic [31:0]       timeout_q, timeout_d;
    logic [31:0]       wdog_q, wdog_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic              irq_q, irq_d;

    logic [7:0]        word_addr;
    logic              wr_en, wr_ctrl, wr_stat, wr_tmo, go, abort;
    logic [ITER_W-1:0] wr_iter, iter_done_inc;
    logic [31:0]       wdog_inc;
    logic              tmo_hit;
    logic [31:0]       ctrl_rd, stat_rd;

    assign word_addr     = paddr & 8'hFC;
    assign wr_en         = psel & penable & pwrite;
    assign wr_ctrl       = wr_en && (word_addr == A_CTRL);
    assign wr_stat       = wr_en && (word_addr == A_STATUS);
    assign wr_tmo        = wr_en && (word_addr == A_TIMEOUT);
    assign go            = wr_ctrl & pwdata[0];
    assign abort         = wr_ctrl & pwdata[1];
    assign wr_iter       = pwdata[16 +: ITER_W];
    assign iter_done_inc = iter_done_q + ITER_W'(1);
    assign wdog_inc      = wdog_q + 32'd1;
    assign tmo_hit       = (timeout_q != 32'd0) && (wdog_inc == timeout_q);

    assign eng_start = (state_q == S_START);
    assign busy      = (state_q != S_IDLE);
    assign irq       = irq_q;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        run_iter_d  = run_iter_q;
        iter_done_d = iter_done_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        tmo_d       = tmo_q;
        aborted_d   = aborted_q;
        spur_d      = spur_q;
        badgo_d     = badgo_q;
        timeout_d   = timeout_q;
        wdog_d      = wdog_q;
        cycles_d    = cycles_q;

        if (wr_ctrl) begin
            irq_en_d = pwdata[2];
            iter_d   = wr_iter;
        end
        if (wr_tmo) begin
            timeout_d = pwdata;
        end
        // Clears go first so a hardware set in the same cycle overrides them.
        if (wr_stat) begin
            done_d    = done_q    & ~pwdata[1];
            tmo_d     = tmo_q     & ~pwdata[2];
            aborted_d = aborted_q & ~pwdata[3];
            spur_d    = spur_q    & ~pwdata[4];
            badgo_d   = badgo_q   & ~pwdata[5];
        end

        if (state_q != S_IDLE && cycles_q != CYC_ONES) begin
            cycles_d = cycles_q + CYC_W'(1);
        end

        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (wr_iter != '0) begin
                            state_d     = S_WAIT_RDY;
                            run_iter_d  = wr_iter;
                            iter_done_d = '0;
                            cycles_d    = '0;
                            wdog_d      = '0;
                        end else begin
                            badgo_d = 1'b1;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    wdog_d = wdog_inc;
                    if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (eng_ready) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    wdog_d = wdog_inc;
                    if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // A finish landing on the expiry cycle still counts.
                    if (eng_finish) begin
                        iter_done_d = iter_done_inc;
                        wdog_d      = '0;
                        state_d     = (iter_done_inc == run_iter_q) ? S_DONE : S_WAIT_RDY;
                    end else if (tmo_hit) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (eng_finish && state_q != S_RUN) begin
            spur_d = 1'b1;
        end

        irq_d = irq_en_d & (done_d | tmo_d | aborted_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            iter_q      <= '0;
            run_iter_q  <= '0;
            iter_done_q <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            aborted_q   <= 1'b0;
            spur_q      <= 1'b0;
            badgo_q     <= 1'b0;
            timeout_q   <= TMO_DEFAULT;
            wdog_q      <= '0;
            cycles_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            run_iter_q  <= run_iter_d;
            iter_done_q <= iter_done_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            aborted_q   <= aborted_d;
            spur_q      <= spur_d;
            badgo_q     <= badgo_d;
            timeout_q   <= timeout_d;
            wdog_q      <= wdog_d;
            cycles_q    <= cycles_d;
            irq_q       <= irq_d;
        end
    end

    // Read data is forced to zero when not selected so it can share an OR bus.
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[2]              = irq_en_q;
        ctrl_rd[16 +: ITER_W]   = iter_q;
        stat_rd                 = '0;
        stat_rd[5:0]            = {badgo_q, spur_q, aborted_q, tmo_q, done_q, busy};
        stat_rd[16 +: ITER_W]   = iter_done_q;
        prdata                  = '0;
        if (psel && !pwrite) begin
            case (word_addr)
                A_CTRL:    prdata = ctrl_rd;
                A_STATUS:  prdata = stat_rd;
                A_TIMEOUT: prdata = timeout_q;
                A_CYCLES:  prdata = 32'(cycles_q);
                default:   prdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_diagram_step_ctrl.sv
// Self-checking bench for diagram_step_ctrl: a behavioural engine model answers start
// pulses; register readbacks are checked against expected values queued per scenario.
module tb_diagram_step_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h00;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        eng_start;
    logic        eng_ready = 1'b1;
    logic        eng_finish = 1'b0;
    logic        busy;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // engine model controls (written by the main thread only)
    int fin_delay = 10;
    bit fin_en = 1'b1;
    int spur_req = 0;
    // engine model state (written by the model only)
    int fin_cnt = 0;
    int rdy_cnt = 0;
    int starts = 0;
    int dbl = 0;
    int spur_done = 0;
    bit prev_start = 1'b0;

    diagram_step_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .eng_start  (eng_start),
        .eng_ready  (eng_ready),
        .eng_finish (eng_finish),
        .busy       (busy),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Engine: finish fin_delay cycles after a start, ready again 2 cycles after finish.
    always @(negedge clk) begin
        eng_finish = 1'b0;
        if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) begin
                eng_finish = fin_en;
                rdy_cnt = 2;
            end
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) eng_ready = 1'b1;
        end
        if (spur_req != spur_done) begin
            eng_finish = 1'b1;
            spur_done++;
        end
        if (eng_start) begin
            if (prev_start) dbl++;
            starts++;
            eng_ready = 1'b0;
            fin_cnt = fin_delay;
        end
        prev_start = eng_start;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1 data = prdata;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({eng_start, busy, irq} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs: got %b want 000", {eng_start, busy, irq});
        end
        checks++;
        if (prdata !== 32'h0) begin
            failures++; $display("FAIL reset_prdata: got %h want 00000000", prdata);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h000F_FFFF);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            apb_read(8'(i * 4), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                failures++; $display("FAIL reset_reg%0d: got %h want %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_iter_run();
        int s0, n, exp_cyc;
        bit to;
        logic [31:0] rd, exp;
        n = 3;
        apb_write(8'h04, 32'h3E);
        apb_write(8'h08, 32'd100);
        s0 = starts;
        apb_write(8'h00, (32'(n) << 16) | 32'h5);
        wait_idle(300, to);
        checks++;
        if (to) begin failures++; $display("FAIL run3_idle: got busy want idle"); end
        checks++;
        if (starts - s0 != n) begin failures++; $display("FAIL run3_starts: got %0d want %0d", starts - s0, n); end
        checks++;
        if (dbl != 0) begin failures++; $display("FAIL run3_pulse_width: got %0d long pulses want 0", dbl); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL run3_irq: got %b want 1", irq); end
        // first iteration: 1 wait + 1 start + run; later: 2 wait + 1 start + run; then DONE
        exp_cyc = (1 + 1 + fin_delay) + (n - 1) * (2 + 1 + fin_delay) + 1;
        exp_q.push_back((32'(n) << 16) | 32'h4);
        exp_q.push_back((32'(n) << 16) | 32'h2);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'(exp_cyc));
        for (int i = 0; i < 4; i++) begin
            apb_read(8'(i * 4), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                failures++; $display("FAIL run3_reg%0d: got %h want %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_timeout();
        int s0;
        logic [31:0] rd, exp;
        apb_write(8'h04, 32'h3E);
        apb_write(8'h08, 32'd20);
        s0 = starts;
        fin_en = 1'b0;
        apb_write(8'h00, (32'd2 << 16) | 32'h5);
        repeat (19) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy_before: got %b want 1", busy); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL tmo_busy_go22: got %b want 0", busy); end
        checks++;
        if (starts - s0 != 1) begin failures++; $display("FAIL tmo_starts: got %0d want 1", starts - s0); end
        fin_en = 1'b1;
        exp_q.push_back(32'h0000_0004);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL tmo_status: got %h want %h", rd, exp); end
    endtask

    task automatic test_abort();
        int s0, nfin;
        logic [31:0] rd, exp;
        apb_write(8'h04, 32'h3E);
        apb_write(8'h08, 32'd100);
        s0 = starts;
        apb_write(8'h00, (32'd5 << 16) | 32'h5);
        nfin = 0;
        for (int i = 0; i < 100 && nfin < 2; i++) begin
            @(posedge clk);
            if (eng_finish) nfin++;
        end
        checks++;
        if (nfin != 2) begin failures++; $display("FAIL abort_fin_wait: got %0d finishes want 2", nfin); end
        apb_write(8'h00, (32'd5 << 16) | 32'h6);
        repeat (20) @(negedge clk);
        checks++;
        if (starts - s0 != 2) begin failures++; $display("FAIL abort_starts: got %0d want 2", starts - s0); end
        checks++;
        if ({busy, irq} !== 2'b01) begin failures++; $display("FAIL abort_busy_irq: got %b want 01", {busy, irq}); end
        exp_q.push_back(32'h0002_0008);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL abort_status: got %h want %h", rd, exp); end
        apb_write(8'h04, 32'h8);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL abort_irq_clear: got %b want 0", irq); end
        exp_q.push_back(32'h0002_0000);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL abort_w1c_status: got %h want %h", rd, exp); end
    endtask

    task automatic test_badgo_and_busy_go();
        int s0;
        bit to;
        logic [31:0] rd, exp;
        apb_write(8'h04, 32'h3E);
        s0 = starts;
        apb_write(8'h00, 32'h1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || starts != s0) begin
            failures++; $display("FAIL badgo_idle: got busy=%b starts=%0d want busy=0 starts=0", busy, starts - s0);
        end
        exp_q.push_back(32'h0002_0020);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL badgo_status: got %h want %h", rd, exp); end
        apb_write(8'h04, 32'h3E);
        s0 = starts;
        apb_write(8'h00, (32'd4 << 16) | 32'h1);
        apb_write(8'h00, 32'h1);
        wait_idle(300, to);
        checks++;
        if (to) begin failures++; $display("FAIL busygo_idle: got busy want idle"); end
        checks++;
        if (starts - s0 != 4) begin failures++; $display("FAIL busygo_starts: got %0d want 4", starts - s0); end
        exp_q.push_back(32'h0004_0002);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL busygo_status: got %h want %h", rd, exp); end
    endtask

    task automatic test_finish_vs_timeout();
        bit to;
        logic [31:0] rd, exp;
        // finish arrives when the watchdog count reaches TIMEOUT=12
        apb_write(8'h04, 32'h3E);
        apb_write(8'h08, 32'd12);
        apb_write(8'h00, (32'd1 << 16) | 32'h1);
        wait_idle(100, to);
        exp_q.push_back(32'h0001_0002);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (to || rd !== exp) begin failures++; $display("FAIL coincide_status: got %h want %h", rd, exp); end
        // finish while idle
        apb_write(8'h04, 32'h3E);
        repeat (2) @(negedge clk);
        spur_req++;
        repeat (3) @(negedge clk);
        exp_q.push_back(32'h0001_0010);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin failures++; $display("FAIL spurious_status: got %h want %h", rd, exp); end
        // one cycle shorter: watchdog wins, the late finish lands in IDLE
        apb_write(8'h04, 32'h3E);
        apb_write(8'h08, 32'd11);
        apb_write(8'h00, (32'd1 << 16) | 32'h1);
        wait_idle(100, to);
        repeat (4) @(negedge clk);
        exp_q.push_back(32'h0000_0014);
        apb_read(8'h04, rd);
        exp = exp_q.pop_front();
        checks++;
        if (to || rd !== exp) begin failures++; $display("FAIL tmo_edge_status: got %h want %h", rd, exp); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] rd, exp;
        apb_write(8'h04, 32'h3E);
        apb_write(8'h00, (32'd1 << 16) | 32'h5);
        @(negedge clk);
        #1;
        checks++;
        if (eng_start !== 1'b1) begin failures++; $display("FAIL rst_in_start: got %b want 1", eng_start); end
        reset = 1'b1;
        #1;
        checks++;
        if ({eng_start, busy} !== 2'b00) begin
            failures++; $display("FAIL rst_async_outputs: got %b want 00", {eng_start, busy});
        end
        repeat (15) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b want 0", irq); end
        reset = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h000F_FFFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 5; i++) begin
            apb_read(8'(i * 4), rd);
            exp = exp_q.pop_front();
            checks++;
            if (rd !== exp) begin
                failures++; $display("FAIL rst_reg%0d: got %h want %h", i, rd, exp);
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b1; pwrite = 1'b0; paddr = 8'h08;
        #1;
        checks++;
        if (prdata !== 32'h0) begin failures++; $display("FAIL orbus_unselected: got %h want 00000000", prdata); end
        penable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_iter_run();
        test_timeout();
        test_abort();
        test_badgo_and_busy_go();
        test_finish_vs_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/diagram_step_ctrl.md
Name: diagram_step_ctrl

Overview:
APB-programmable sequencer for the Diagram_step_top engine at the 0x4101_0000 window. It issues start pulses against the engine's ready/finish handshake and runs a programmed number of back-to-back iterations. It enforces a per-iteration watchdog, records cycle counts and status, and raises an interrupt on completion. It sits between the APB fabric, which receives its prdata through the shared OR read bus, and the engine's start/ready/finish pins.

Parameters:
ITER_W, 16, width of iteration count and completed-iteration counter
TMO_DEFAULT, 32'h000F_FFFF, reset value of TIMEOUT register (cycles)
CYC_W, 32, width of run-cycle counter (saturating)

Ports:
clk  in  1  engine/APB clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
psel  in  1  APB select, pre-decoded for this window
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  8  APB byte offset; bits [1:0] ignored
pwdata  in  32  APB write data
prdata  out  32  read data; 0 whenever psel=0 (OR-bus safe)
eng_start  out  1  one-cycle start pulse to engine
eng_ready  in  1  engine idle/ready level
eng_finish  in  1  engine one-cycle completion pulse
busy  out  1  sequencer active (state != IDLE)
irq  out  1  level interrupt

Behaviour:
- Always decided: one clock (clk); reset asynchronous, active-high (reset); all flops clear on reset assertion independent of clk.
- APB: zero wait states. Write commits on psel&penable&pwrite. Read data is combinational from registers when psel&!pwrite, else 0. Unmapped offsets read 0; writes to them are ignored.
- 0x00 CTRL (RW except W1 bits): bit0 GO (W1, self-clearing, reads 0); bit1 ABORT (W1, reads 0); bit2 IRQ_EN; [31:16] ITER. Reset 0.
- 0x04 STATUS: bit0 busy (RO); bit1 DONE (W1C); bit2 TMO (W1C); bit3 ABORTED (W1C); bit4 SPURIOUS (W1C); bit5 BADGO (W1C); [31:16] ITER_DONE (RO). Reset 0.
- 0x08 TIMEOUT (RW): reset TMO_DEFAULT; 0 disables the watchdog.
- 0x0C CYCLES (RO): clk count from GO acceptance to DONE/TMO/abort. Saturates at all-ones. Reset 0.
- FSM states:
  - IDLE: on GO with ITER!=0, latch ITER into run_iter, clear ITER_DONE and CYCLES, go to WAIT_RDY. On GO with ITER==0, set BADGO and stay in IDLE.
  - WAIT_RDY: when eng_ready=1, go to START.
  - START: eng_start=1 for exactly this cycle; go to RUN.
  - RUN: on eng_finish, ITER_DONE+1. If new ITER_DONE==run_iter, go to DONE; else go to WAIT_RDY.
  - DONE: set DONE; go to IDLE next cycle.
- Latency: GO write in cycle T puts the FSM in WAIT_RDY at T+1. If eng_ready=1, eng_start is high in T+2. Back-to-back iterations place a minimum of 2 cycles between finish and the next start.
- Watchdog: a per-iteration counter clears on entering WAIT_RDY and increments in WAIT_RDY/START/RUN. When it reaches TIMEOUT!=0, set TMO and go to IDLE; DONE is not set.
  - If eng_finish and timeout occur in the same cycle, finish wins: the iteration counts and no TMO is raised.
- ABORT in any non-IDLE state: go to IDLE next cycle, set ABORTED, no DONE. A pending eng_start cycle (state START) still completes its single pulse. ABORT in IDLE is ignored.
- GO while busy is ignored, with no flag raised. Writes to ITER/IRQ_EN while busy are accepted but the running count uses the latched run_iter.
- eng_finish outside RUN sets SPURIOUS and is otherwise ignored.
- GO and ABORT written together in IDLE: GO is taken and ABORT ignored.
- W1C on a flag in the same cycle the hardware sets it: the set wins.
- ITER_DONE wraps never: bounded by run_iter ≤ 2^ITER_W−1.
- irq = IRQ_EN & (DONE | TMO | ABORTED), registered, reset 0.
- Output reset values: eng_start=0, busy=0, irq=0, prdata=0.
- Reset asserted mid-run forces IDLE immediately; eng_start drops asynchronously.

Test Plan:
1. ITER=3, TIMEOUT=100, eng model: ready after 2 cycles, finish 10 cycles after start, GO -> exactly 3 single-cycle eng_start pulses; STATUS reads 0x0003_0002; irq=1 with IRQ_EN=1; CYCLES within the model-predicted value ±0.
2. ITER=2, TIMEOUT=20, model never asserts finish -> one start pulse; TMO=1, DONE=0, ITER_DONE=0, busy=0 at cycle GO+22.
3. ITER=5, abort written after the second finish -> no further eng_start; ABORTED=1, ITER_DONE=2, DONE=0; a subsequent W1C of 0x8 clears ABORTED and drops irq next cycle.
4. GO with ITER=0 -> BADGO=1, busy stays 0, no start; GO while busy (ITER=4 run) -> exactly 4 starts total.
5. Finish and watchdog expiry in the same cycle (TIMEOUT set so they coincide) -> iteration counted, TMO=0; finish pulse while IDLE -> SPURIOUS=1.
6. Reset asserted while in START -> eng_start=0 and busy=0 combinationally; all registers read their reset values (TIMEOUT=0x000F_FFFF); prdata=0 with psel=0 during all reads of other windows.
